// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states and checksum seed.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_VERIFY = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Every checksum bit starts from this value.
    localparam logic CK_INIT_BIT = 1'b0;

endpackage

// File: rtl/imem_cksum.sv
// Rotate-left-by-one / XOR accumulator used for both the write-side and readback checksums.
module imem_cksum
    import imem_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] ck
);

    logic [DATA_WIDTH-1:0] ck_q;
    logic [DATA_WIDTH-1:0] ck_d;

    always_comb begin
        ck_d = ck_q;
        if (clear) begin
            ck_d = {DATA_WIDTH{CK_INIT_BIT}};
        end else if (en) begin
            ck_d = {ck_q[DATA_WIDTH-2:0], ck_q[DATA_WIDTH-1]} ^ din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ck_q <= {DATA_WIDTH{CK_INIT_BIT}};
        end else begin
            ck_q <= ck_d;
        end
    end

    assign ck = ck_q;

endmodule

// File: rtl/imem_loader.sv
// Host-side instruction memory writer/verifier: streams words into memory from base_addr,
// reads the same region back and compares rotate-XOR checksums.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  verify_ok,
    output logic                  verify_err
);

    localparam logic [ADDR_WIDTH:0] ONE_CNT   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH:0]   k_q, k_d;
    logic [ADDR_WIDTH:0]   j_q, j_d;
    logic                  rd_issue_q, rd_issue_d;
    logic                  rd_data_q, rd_data_d;
    logic                  s_ready_q, s_ready_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_waddr_q, mem_waddr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [ADDR_WIDTH-1:0] mem_raddr_q, mem_raddr_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic                  done_q, done_d;
    logic                  verify_ok_q, verify_ok_d;
    logic                  verify_err_q, verify_err_d;

    logic                  ck_clear;
    logic                  hs;
    logic                  rck_en;
    logic [DATA_WIDTH-1:0] wck;
    logic [DATA_WIDTH-1:0] rck;

    assign hs     = (state_q == ST_LOAD) && s_ready_q && s_valid;
    assign rck_en = (state_q == ST_VERIFY) && rd_data_q;

    imem_cksum #(.DATA_WIDTH(DATA_WIDTH)) u_wck (
        .clk   (clk),
        .reset (reset),
        .clear (ck_clear),
        .en    (hs),
        .din   (s_data),
        .ck    (wck)
    );

    imem_cksum #(.DATA_WIDTH(DATA_WIDTH)) u_rck (
        .clk   (clk),
        .reset (reset),
        .clear (ck_clear),
        .en    (rck_en),
        .din   (mem_rdata),
        .ck    (rck)
    );

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        count_d      = count_q;
        k_d          = k_q;
        j_d          = j_q;
        rd_issue_d   = 1'b0;
        rd_data_d    = rd_issue_q;
        s_ready_d    = s_ready_q;
        mem_we_d     = 1'b0;
        mem_waddr_d  = mem_waddr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_raddr_d  = mem_raddr_q;
        cpu_hold_d   = cpu_hold_q;
        done_d       = 1'b0;
        verify_ok_d  = verify_ok_q;
        verify_err_d = verify_err_q;
        ck_clear     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d       = base_addr;
                    count_d      = word_count;
                    k_d          = '0;
                    j_d          = '0;
                    cpu_hold_d   = 1'b1;
                    verify_ok_d  = 1'b0;
                    verify_err_d = 1'b0;
                    ck_clear     = 1'b1;
                    if (word_count == '0) begin
                        state_d     = ST_DONE;
                        verify_ok_d = 1'b1;
                    end else if (word_count > DEPTH_CNT) begin
                        state_d      = ST_DONE;
                        verify_err_d = 1'b1;
                    end else begin
                        state_d   = ST_LOAD;
                        s_ready_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (hs) begin
                    mem_we_d    = 1'b1;
                    mem_waddr_d = base_q + k_q[ADDR_WIDTH-1:0];
                    mem_wdata_d = s_data;
                    k_d         = k_q + ONE_CNT;
                    if (k_q == count_q - ONE_CNT) begin
                        s_ready_d = 1'b0;
                        state_d   = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Last write commits at the end of this cycle; first read issues next.
                state_d     = ST_VERIFY;
                mem_raddr_d = base_q;
                rd_issue_d  = 1'b1;
                j_d         = ONE_CNT;
            end
            ST_VERIFY: begin
                if (j_q != count_q) begin
                    mem_raddr_d = base_q + j_q[ADDR_WIDTH-1:0];
                    rd_issue_d  = 1'b1;
                    j_d         = j_q + ONE_CNT;
                end else if (!rd_issue_q && rd_data_q) begin
                    // Final readback word is being folded into rck this cycle.
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (rck == wck) begin
                    verify_ok_d = 1'b1;
                end else begin
                    verify_err_d = 1'b1;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                done_d     = 1'b1;
                cpu_hold_d = 1'b0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            base_q       <= '0;
            count_q      <= '0;
            k_q          <= '0;
            j_q          <= '0;
            rd_issue_q   <= 1'b0;
            rd_data_q    <= 1'b0;
            s_ready_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_waddr_q  <= '0;
            mem_wdata_q  <= '0;
            mem_raddr_q  <= '0;
            cpu_hold_q   <= 1'b0;
            done_q       <= 1'b0;
            verify_ok_q  <= 1'b0;
            verify_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            count_q      <= count_d;
            k_q          <= k_d;
            j_q          <= j_d;
            rd_issue_q   <= rd_issue_d;
            rd_data_q    <= rd_data_d;
            s_ready_q    <= s_ready_d;
            mem_we_q     <= mem_we_d;
            mem_waddr_q  <= mem_waddr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_raddr_q  <= mem_raddr_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
            verify_ok_q  <= verify_ok_d;
            verify_err_q <= verify_err_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_waddr  = mem_waddr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_raddr  = mem_raddr_q;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign verify_ok  = verify_ok_q;
    assign verify_err = verify_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader with a registered-read memory model.
module tb_imem_loader;

    localparam int AW = 9;
    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   word_count;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata;
    logic          cpu_hold;
    logic          done;
    logic          verify_ok;
    logic          verify_err;

    imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .verify_ok  (verify_ok),
        .verify_err (verify_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: synchronous write, 1-cycle registered read, optional single-bit corruption.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          corrupt_en;
    logic [AW-1:0] corrupt_addr;

    always @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        mem_rdata <= mem[mem_raddr] ^ ((corrupt_en && mem_raddr == corrupt_addr) ? 32'h1 : 32'h0);
    end

    int asserts;
    int errors;
    int cyc;
    int we_cnt;
    int done_cnt;
    int last_we_cyc;
    int done_cyc;
    logic [AW+DW-1:0] exp_q [$];
    logic [AW-1:0]    rlog [$];

    // Write-port scoreboard and done/readback monitors.
    always @(negedge clk) begin
        logic [AW+DW-1:0] e;
        cyc++;
        if (mem_we) begin
            we_cnt++;
            last_we_cyc = cyc;
            asserts++;
            $display("write addr=%0d data=%h", mem_waddr, mem_wdata);
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", mem_waddr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({mem_waddr, mem_wdata} !== e) begin
                    errors++;
                    $display("FAIL write_beat: got addr=%0d data=%h, required addr=%0d data=%h",
                             mem_waddr, mem_wdata, e[AW+DW-1:DW], e[DW-1:0]);
                end
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (cpu_hold && (rlog.size() == 0 || rlog[rlog.size()-1] != mem_raddr)) rlog.push_back(mem_raddr);
    end

    function automatic logic [DW-1:0] word_of(input int seed, input int idx);
        return DW'(seed * (idx + 1));
    endfunction

    // Starts a load and streams words until stop_at beats are accepted; returns s_ready one cycle after start.
    task automatic drive_load(input int base, input int cnt, input int seed, input bit gaps,
                              input int stop_at, output bit rdy_after_start);
        int  idx;
        int  budget;
        bit  tog;
        bit  v;
        @(negedge clk);
        start      = 1'b1;
        base_addr  = AW'(base);
        word_count = (AW+1)'(cnt);
        @(negedge clk);
        start = 1'b0;
        rdy_after_start = s_ready;
        idx    = 0;
        budget = 0;
        tog    = 1'b1;
        while (idx < stop_at && budget < 1000) begin
            v   = gaps ? tog : 1'b1;
            tog = ~tog;
            s_valid = v;
            s_data  = v ? word_of(seed, idx) : 32'hDEAD_BEEF;
            if (v && s_ready) begin
                exp_q.push_back({AW'(base + idx), word_of(seed, idx)});
                idx++;
            end
            @(negedge clk);
            budget++;
        end
        s_valid = 1'b0;
        s_data  = '0;
        if (idx < stop_at) begin
            asserts++;
            errors++;
            $display("FAIL load_timeout: accepted %0d beats, required %0d", idx, stop_at);
        end
    endtask

    task automatic wait_done(input string tag, output int ncyc);
        ncyc = 0;
        while (!done && ncyc < 2000) begin
            @(negedge clk);
            ncyc++;
        end
        if (!done) begin
            asserts++;
            errors++;
            $display("FAIL %s_done_timeout: done=%0b after %0d cycles, required 1", tag, done, ncyc);
        end
        $display("%s: done after %0d cycles ok=%0b err=%0b", tag, ncyc, verify_ok, verify_err);
    endtask

    task automatic test_reset();
        asserts++;
        if ({s_ready, mem_we, cpu_hold, done, verify_ok, verify_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, required 000000",
                     {s_ready, mem_we, cpu_hold, done, verify_ok, verify_err});
        end
        asserts++;
        if ({mem_waddr, mem_wdata, mem_raddr} !== '0) begin
            errors++;
            $display("FAIL reset_bus: got waddr=%0d wdata=%h raddr=%0d, required 0", mem_waddr, mem_wdata, mem_raddr);
        end
    endtask

    task automatic test_basic();
        bit rdy;
        int n;
        int we0;
        int dn0;
        we0 = we_cnt;
        dn0 = done_cnt;
        drive_load(0, 4, 32'h11, 1'b0, 4, rdy);
        asserts++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL basic_ready_latency: s_ready=%0b one cycle after start, required 1", rdy);
        end
        wait_done("basic", n);
        @(negedge clk);
        asserts++;
        if (cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL basic_cpu_hold: got %0b after done, required 0", cpu_hold);
        end
        repeat (3) @(negedge clk);
        asserts++;
        if (we_cnt - we0 != 4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_writes: got %0d writes, %0d pending, required 4 and 0", we_cnt - we0, exp_q.size());
        end
        asserts++;
        if (verify_ok !== 1'b1 || verify_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_verify: ok=%0b err=%0b, required ok=1 err=0", verify_ok, verify_err);
        end
        asserts++;
        if (done_cnt - dn0 != 1) begin
            errors++;
            $display("FAIL basic_done_pulses: got %0d, required 1", done_cnt - dn0);
        end
        asserts++;
        if (done_cyc - last_we_cyc != 8) begin
            errors++;
            $display("FAIL basic_latency: last write to done %0d cycles, required 8", done_cyc - last_we_cyc);
        end
    endtask

    task automatic test_gaps();
        bit rdy;
        int n;
        int we0;
        we0 = we_cnt;
        drive_load(0, 4, 32'h11, 1'b1, 4, rdy);
        wait_done("gaps", n);
        @(negedge clk);
        asserts++;
        if (we_cnt - we0 != 4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL gaps_writes: got %0d writes, %0d pending, required 4 and 0", we_cnt - we0, exp_q.size());
        end
        asserts++;
        if (verify_ok !== 1'b1 || verify_err !== 1'b0) begin
            errors++;
            $display("FAIL gaps_verify: ok=%0b err=%0b, required ok=1 err=0", verify_ok, verify_err);
        end
    endtask

    task automatic test_wrap();
        bit rdy;
        int n;
        int sz;
        logic [AW-1:0] exp_ra [4];
        exp_ra[0] = 9'd510;
        exp_ra[1] = 9'd511;
        exp_ra[2] = 9'd0;
        exp_ra[3] = 9'd1;
        rlog.delete();
        drive_load(510, 4, 32'h0A0B0C01, 1'b0, 4, rdy);
        wait_done("wrap", n);
        @(negedge clk);
        sz = rlog.size();
        asserts++;
        if (sz < 4) begin
            errors++;
            $display("FAIL wrap_raddr_count: got %0d distinct read addresses, required at least 4", sz);
        end else begin
            for (int i = 0; i < 4; i++) begin
                asserts++;
                if (rlog[sz-4+i] !== exp_ra[i]) begin
                    errors++;
                    $display("FAIL wrap_raddr%0d: got %0d, required %0d", i, rlog[sz-4+i], exp_ra[i]);
                end
            end
        end
        asserts++;
        if (verify_ok !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL wrap_verify: ok=%0b pending=%0d, required ok=1 pending=0", verify_ok, exp_q.size());
        end
    endtask

    task automatic test_corrupt();
        bit rdy;
        int n;
        corrupt_en   = 1'b1;
        corrupt_addr = 9'd2;
        drive_load(0, 4, 32'h55, 1'b0, 4, rdy);
        wait_done("corrupt", n);
        @(negedge clk);
        corrupt_en = 1'b0;
        asserts++;
        if (verify_err !== 1'b1 || verify_ok !== 1'b0) begin
            errors++;
            $display("FAIL corrupt_verify: ok=%0b err=%0b, required ok=0 err=1", verify_ok, verify_err);
        end
    endtask

    task automatic test_count_edges();
        bit rdy;
        int n;
        int we0;
        we0 = we_cnt;
        drive_load(0, 0, 0, 1'b0, 0, rdy);
        wait_done("count0", n);
        asserts++;
        if (n + 1 > 3) begin
            errors++;
            $display("FAIL count0_latency: done %0d cycles after start, required <= 3", n + 1);
        end
        @(negedge clk);
        asserts++;
        if (verify_ok !== 1'b1 || verify_err !== 1'b0 || we_cnt != we0) begin
            errors++;
            $display("FAIL count0_result: ok=%0b err=%0b writes=%0d, required ok=1 err=0 writes=0",
                     verify_ok, verify_err, we_cnt - we0);
        end
        drive_load(0, 513, 0, 1'b0, 0, rdy);
        asserts++;
        if (rdy !== 1'b0) begin
            errors++;
            $display("FAIL count513_ready: s_ready=%0b, required 0", rdy);
        end
        wait_done("count513", n);
        @(negedge clk);
        asserts++;
        if (verify_err !== 1'b1 || verify_ok !== 1'b0 || we_cnt != we0) begin
            errors++;
            $display("FAIL count513_result: ok=%0b err=%0b writes=%0d, required ok=0 err=1 writes=0",
                     verify_ok, verify_err, we_cnt - we0);
        end
    endtask

    task automatic test_reset_mid_load();
        bit rdy;
        int n;
        drive_load(100, 8, 32'h01010101, 1'b0, 2, rdy);
        #2;
        reset = 1'b1;
        #1;
        asserts++;
        if ({s_ready, mem_we, cpu_hold, done, verify_ok, verify_err} !== 6'b0) begin
            errors++;
            $display("FAIL abort_ctrl: got %b, required 000000",
                     {s_ready, mem_we, cpu_hold, done, verify_ok, verify_err});
        end
        asserts++;
        if ({mem_waddr, mem_wdata, mem_raddr} !== '0) begin
            errors++;
            $display("FAIL abort_bus: got waddr=%0d wdata=%h raddr=%0d, required 0", mem_waddr, mem_wdata, mem_raddr);
        end
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        drive_load(100, 8, 32'h01010101, 1'b0, 8, rdy);
        wait_done("reload", n);
        @(negedge clk);
        asserts++;
        if (verify_ok !== 1'b1 || verify_err !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL reload_verify: ok=%0b err=%0b pending=%0d, required ok=1 err=0 pending=0",
                     verify_ok, verify_err, exp_q.size());
        end
    endtask

    initial begin
        asserts      = 0;
        errors       = 0;
        cyc          = 0;
        we_cnt       = 0;
        done_cnt     = 0;
        last_we_cyc  = 0;
        done_cyc     = 0;
        corrupt_en   = 1'b0;
        corrupt_addr = '0;
        reset        = 1'b1;
        start        = 1'b0;
        base_addr    = '0;
        word_count   = '0;
        s_valid      = 1'b0;
        s_data       = '0;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        @(negedge clk);
        test_basic();
        test_gaps();
        test_wrap();
        test_corrupt();
        test_count_edges();
        test_reset_mid_load();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, errors);
        $finish;
    end

endmodule
